// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the sequential BCD-to-binary decoder.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    // Legacy numeric state codes, reused as the enum encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CONV = ST_CONV,
        DONE = ST_DONE
    } bcd2bin_state_t;

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Valid/ready input (packed BCD) and output (binary + error) channels of bcd_to_bin_seq.
interface bcd_to_bin_seq_if #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_bcd;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      out_bin;
    logic                  out_err;

    modport master (
        output in_valid, in_bcd, out_ready,
        input  in_ready, out_valid, out_bin, out_err
    );

    modport slave (
        input  in_valid, in_bcd, out_ready,
        output in_ready, out_valid, out_bin, out_err
    );
endinterface

// File: rtl/bcd_mac_step.sv
// One decimal multiply-accumulate step: acc_out = acc_in*10 + digit, plus a non-BCD digit flag.
module bcd_mac_step
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W = 14
) (
    input  logic [BIN_W-1:0]   acc_in,
    input  logic [DIGIT_W-1:0] digit,
    output logic [BIN_W-1:0]   acc_out,
    output logic               digit_bad
);
    // x*10 as (x<<3)+(x<<1); wraps modulo 2**BIN_W
    assign acc_out   = (acc_in << 3) + (acc_in << 1) + BIN_W'(digit);
    assign digit_bad = (digit > BCD_MAX);
endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary decoder, MS digit first, one digit per clock.
// Optional macro BCD_TO_BIN_ERR_EN: flag words containing a digit > 9 on out_err.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input logic             clk,
    input logic             reset,
    bcd_to_bin_seq_if.slave bus
);
    localparam int unsigned SH_W     = DIGIT_W * DIGITS;
    localparam int unsigned CNT_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

    bcd2bin_state_t   state;
    logic [SH_W-1:0]  shreg;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] acc;
    logic [BIN_W-1:0] acc_next;
    logic [BIN_W-1:0] out_bin_r;
    logic             err;
    logic             err_next;
    logic             out_err_r;
    logic             digit_bad;

    bcd_mac_step #(.BIN_W(BIN_W)) u_step (
        .acc_in    (acc),
        .digit     (shreg[SH_W-1 -: DIGIT_W]),
        .acc_out   (acc_next),
        .digit_bad (digit_bad)
    );

`ifdef BCD_TO_BIN_ERR_EN
    assign err_next = err | digit_bad;
`else
    logic [1:0] unused_err;
    assign unused_err = {err, digit_bad};
    assign err_next   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            acc       <= '0;
            err       <= 1'b0;
            out_bin_r <= '0;
            out_err_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        shreg <= bus.in_bcd;
                        acc   <= '0;
                        cnt   <= CNT_LAST;
                        err   <= 1'b0;
                        state <= CONV;
                    end
                end
                CONV: begin
                    acc   <= acc_next;
                    err   <= err_next;
                    shreg <= shreg << DIGIT_W;
                    cnt   <= cnt - 1'b1;
                    // Output copy keeps the last result visible after returning to IDLE.
                    if (cnt == '0) begin
                        out_bin_r <= acc_next;
                        out_err_r <= err_next;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !reset;
    assign bus.out_valid = (state == DONE);
    assign bus.out_bin   = out_bin_r;
    assign bus.out_err   = out_err_r;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Randomized self-checking bench for bcd_to_bin_seq against a positional-weight decimal model.
module tb_bcd_to_bin_seq;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned BIN_W  = 14;

    logic clk = 1'b0;
    logic reset;
    int   pass_cnt = 0;
    int   total    = 0;

    always #5 clk = ~clk;

    bcd_to_bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [BIN_W-1:0] ref_bin(input logic [4*DIGITS-1:0] w);
        longint unsigned sum = 0;
        longint unsigned weight = 1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            sum += longint'(w[4*i +: 4]) * weight;
            weight *= 10;
        end
        return BIN_W'(sum % (longint'(1) << BIN_W));
    endfunction

    function automatic logic ref_err(input logic [4*DIGITS-1:0] w);
        logic any_bad = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++)
            if (w[4*i +: 4] > 4'd9) any_bad = 1'b1;
`ifdef BCD_TO_BIN_ERR_EN
        return any_bad;
`else
        return 1'b0 & any_bad;
`endif
    endfunction

    function automatic logic [4*DIGITS-1:0] rand_word(input bit allow_bad);
        logic [4*DIGITS-1:0] w;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (allow_bad && $urandom_range(0, 7) == 0)
                w[4*i +: 4] = 4'($urandom_range(10, 15));
            else
                w[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_word(input logic [4*DIGITS-1:0] w, output bit ok);
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_bcd   = w;
        for (int n = 0; n < 40 && !ok; n++) begin
            if (bus.in_ready) ok = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n, output bit ok);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        ok = bus.out_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_bcd    = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        total++;
        if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
        else pass_cnt++;
        total++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        else pass_cnt++;
        total++;
        if (bus.out_bin !== '0 || bus.out_err !== 1'b0)
            $display("FAIL reset_outputs got=%0d/%b exp=0/0", bus.out_bin, bus.out_err);
        else pass_cnt++;
        reset = 1'b0;
        tick();
        total++;
        if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready);
        else pass_cnt++;
    endtask

    task automatic test_words(input string name, input logic [4*DIGITS-1:0] w);
        bit ok;
        int n;
        bus.out_ready = 1'b1;
        accept_word(w, ok);
        wait_valid(n, ok);
        total++;
        if (!ok || n != int'(DIGITS))
            $display("FAIL %s_latency got=%0d exp=%0d", name, n, DIGITS);
        else pass_cnt++;
        total++;
        if (bus.out_bin !== ref_bin(w) || bus.out_err !== ref_err(w))
            $display("FAIL %s_result word=%h got=%0d/%b exp=%0d/%b", name, w,
                     bus.out_bin, bus.out_err, ref_bin(w), ref_err(w));
        else pass_cnt++;
        tick();
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL %s_handshake got=%b/%b exp=0/1", name, bus.out_valid, bus.in_ready);
        else pass_cnt++;
    endtask

    task automatic test_bad_digit();
        bit ok;
        int n;
        accept_word(16'h12A4, ok);
        wait_valid(n, ok);
        total++;
        if (!ok || bus.out_bin !== 14'd1304)
            $display("FAIL bad_digit_bin got=%0d exp=1304", bus.out_bin);
        else pass_cnt++;
        total++;
`ifdef BCD_TO_BIN_ERR_EN
        if (bus.out_err !== 1'b1) $display("FAIL bad_digit_err got=%b exp=1", bus.out_err);
`else
        if (bus.out_err !== 1'b0) $display("FAIL bad_digit_err got=%b exp=0", bus.out_err);
`endif
        else pass_cnt++;
        tick();
    endtask

    task automatic test_stall();
        bit ok;
        int n;
        logic [4*DIGITS-1:0] w;
        w = rand_word(1'b0);
        bus.out_ready = 1'b0;
        accept_word(w, ok);
        wait_valid(n, ok);
        for (int c = 0; c < 5; c++) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_bin !== ref_bin(w))
                $display("FAIL stall_hold cyc=%0d got=%b/%b/%0d exp=1/0/%0d", c,
                         bus.out_valid, bus.in_ready, bus.out_bin, ref_bin(w));
            else pass_cnt++;
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_bin !== ref_bin(w))
            $display("FAIL stall_release got=%b/%b/%0d exp=0/1/%0d", bus.out_valid,
                     bus.in_ready, bus.out_bin, ref_bin(w));
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen = 1'b0;
        accept_word(16'h5678, ok);
        tick();
        reset = 1'b1;
        tick();
        total++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0)
            $display("FAIL reset_mid_during got=%b/%b exp=0/0", bus.in_ready, bus.out_valid);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        for (int c = 0; c < int'(DIGITS) + 4; c++) begin
            if (bus.out_valid) seen = 1'b1;
            tick();
        end
        total++;
        if (seen !== 1'b0) $display("FAIL reset_mid_discard got=%b exp=0", seen);
        else pass_cnt++;
        test_words("after_reset", 16'h0042);
    endtask

    task automatic test_random();
        bit ok;
        int n;
        int stall;
        logic [4*DIGITS-1:0] w;
        for (int k = 0; k < 24; k++) begin
            w = rand_word(1'b1);
            stall = int'($urandom_range(0, 3));
            bus.out_ready = (stall == 0);
            accept_word(w, ok);
            wait_valid(n, ok);
            repeat (stall) tick();
            total++;
            if (!ok || bus.out_valid !== 1'b1 || bus.out_bin !== ref_bin(w) || bus.out_err !== ref_err(w))
                $display("FAIL random_%0d word=%h got=%0d/%b exp=%0d/%b", k, w,
                         bus.out_bin, bus.out_err, ref_bin(w), ref_err(w));
            else pass_cnt++;
            bus.out_ready = 1'b1;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [4*DIGITS-1:0] words[2];
        logic [BIN_W-1:0] got[$];
        int idx = 0;
        bit acc;
        words[0] = 16'h0001;
        words[1] = 16'h0100;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_bcd    = words[0];
        for (int c = 0; c < 60 && got.size() < 2; c++) begin
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_bin);
            tick();
            if (acc) begin
                idx++;
                if (idx < 2) bus.in_bcd = words[idx];
                else bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        total++;
        if (got.size() != 2) $display("FAIL b2b_count got=%0d exp=2", got.size());
        else pass_cnt++;
        for (int i = 0; i < got.size() && i < 2; i++) begin
            total++;
            if (got[i] !== ref_bin(words[i]))
                $display("FAIL b2b_result_%0d got=%0d exp=%0d", i, got[i], ref_bin(words[i]));
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_words("w1234", 16'h1234);
        test_words("w9999", 16'h9999);
        test_words("w0000", 16'h0000);
        test_bad_digit();
        test_stall();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
